// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions: opcodes, sequencer states, instruction fields.
// Latency: none (definitions only).
// Backpressure: not applicable.
package cpu_ctrl_pkg;

  // Instruction word field positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;

  typedef logic [4:0] opcode_t;
  typedef logic [3:0] reg_idx_t;

  localparam opcode_t OPC_AND = 5'b00001;
  localparam opcode_t OPC_OR  = 5'b00010;
  localparam opcode_t OPC_ADD = 5'b00011;
  localparam opcode_t OPC_SUB = 5'b00100;
  localparam opcode_t OPC_SHR = 5'b00101;
  localparam opcode_t OPC_SHL = 5'b00110;
  localparam opcode_t OPC_ROR = 5'b00111;
  localparam opcode_t OPC_NOT = 5'b01000;
  localparam opcode_t OPC_NEG = 5'b01001;
  localparam opcode_t OPC_MUL = 5'b01010;
  localparam opcode_t OPC_DIV = 5'b01011;

  // IDLE must encode as zero so a cleared state register reads as IDLE
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T3   = 3'd1,
    ST_T4   = 3'd2,
    ST_T5   = 3'd3,
    ST_T6   = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  // Datapath single-bit strobes, kept together so they register as one word
  typedef struct packed {
    logic yin;
    logic zhighin;
    logic zlowin;
    logic zhighout;
    logic zlowout;
    logic hiin;
    logic loin;
  } strobe_t;

  // Opcodes 1..11 are the defined set; everything else traps as illegal
  function automatic logic is_legal(opcode_t o);
    return (o >= OPC_AND) && (o <= OPC_DIV);
  endfunction

  // Single-operand ops skip the second register read in T4
  function automatic logic is_unary(opcode_t o);
    return (o == OPC_NOT) || (o == OPC_NEG);
  endfunction

  // Wide-result ops take an extra cycle to move the high half into HI
  function automatic logic is_muldiv(opcode_t o);
    return (o == OPC_MUL) || (o == OPC_DIV);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundles the sequencer request inputs and datapath control outputs.
// Latency: none (wiring only).
// Backpressure: requester sees busy; start is ignored while busy is high.
interface alu_sequencer_if #(
  parameter int OP_W = 5,
  parameter int NREG = 16
);
  logic            start;
  logic [31:0]     instr;
  logic            busy;
  logic            done;
  logic            illegal;
  logic [NREG-1:0] Rout;
  logic [NREG-1:0] Rin;
  logic            Yin;
  logic            Zhighin;
  logic            Zlowin;
  logic            Zhighout;
  logic            Zlowout;
  logic            HIin;
  logic            LOin;
  logic [OP_W-1:0] op;

  // Requester side: issues instructions, observes controls
  modport master (
    output start, instr,
    input  busy, done, illegal, Rout, Rin, Yin, Zhighin, Zlowin,
           Zhighout, Zlowout, HIin, LOin, op
  );

  // Sequencer side
  modport slave (
    input  start, instr,
    output busy, done, illegal, Rout, Rin, Yin, Zhighin, Zlowin,
           Zhighout, Zlowout, HIin, LOin, op
  );
endinterface

// File: rtl/reg_decode_4to16.sv
// Converts a 4-bit register index plus enable into a 16-bit one-hot select.
// Latency: combinational.
// Backpressure: none.
module reg_decode_4to16 (
  input  logic        en,
  input  logic [3:0]  idx,
  output logic [15:0] onehot
);

  // One bit set at idx when enabled, otherwise all zero
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Micro-sequencer stepping one ALU instruction through T3/T4/T5[/T6]/FIN.
// Latency: done 4 cycles after accept (5 for MUL/DIV); all outputs registered.
// Backpressure: busy high outside IDLE; start while busy is dropped, not queued.
module alu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W = 5,
  parameter int NREG = 16
) (
  input  logic           Clock,
  input  logic           clear,
  alu_sequencer_if.slave bus
);

  state_t   state_q, state_d;
  opcode_t  opcode_q, opcode_d;
  reg_idx_t ra_q, ra_d;
  reg_idx_t rb_q, rb_d;
  reg_idx_t rc_q, rc_d;

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            illegal_q, illegal_d;
  logic [NREG-1:0] rout_q, rout_d;
  logic [NREG-1:0] rin_q, rin_d;
  strobe_t         strb_q, strb_d;
  logic [OP_W-1:0] op_q, op_d;

  logic     rout_en, rin_en;
  reg_idx_t rout_idx;
  logic [15:0] rout_oh, rin_oh;

  // Next state and instruction capture; fields latch only on an IDLE accept
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    rc_d      = rc_q;
    illegal_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          opcode_d = bus.instr[OPC_HI:OPC_LO];
          ra_d     = bus.instr[RA_HI:RA_LO];
          rb_d     = bus.instr[RB_HI:RB_LO];
          rc_d     = bus.instr[RC_HI:RC_LO];
          if (is_legal(opcode_d)) state_d = ST_T3;
          else                    illegal_d = 1'b1;
        end
      end
      ST_T3:   state_d = ST_T4;
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = is_muldiv(opcode_q) ? ST_T6 : ST_FIN;
      ST_T6:   state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Controls decoded from the state being entered so they line up with it once registered
  always_comb begin
    busy_d   = (state_d != ST_IDLE);
    done_d   = 1'b0;
    strb_d   = '0;
    op_d     = '0;
    rout_en  = 1'b0;
    rout_idx = rb_d;
    rin_en   = 1'b0;
    case (state_d)
      ST_T3: begin
        rout_en    = 1'b1;
        rout_idx   = rb_d;
        strb_d.yin = 1'b1;
      end
      ST_T4: begin
        rout_en        = !is_unary(opcode_d);
        rout_idx       = rc_d;
        op_d           = OP_W'(opcode_d);
        strb_d.zhighin = 1'b1;
        strb_d.zlowin  = 1'b1;
      end
      ST_T5: begin
        strb_d.zlowout = 1'b1;
        if (is_muldiv(opcode_d)) strb_d.loin = 1'b1;
        else                     rin_en      = 1'b1;
      end
      ST_T6: begin
        strb_d.zhighout = 1'b1;
        strb_d.hiin     = 1'b1;
      end
      ST_FIN:  done_d = 1'b1;
      default: ;
    endcase
    rout_d = NREG'(rout_oh);
    rin_d  = NREG'(rin_oh);
  end

  reg_decode_4to16 u_rout_dec (
    .en     (rout_en),
    .idx    (rout_idx),
    .onehot (rout_oh)
  );

  reg_decode_4to16 u_rin_dec (
    .en     (rin_en),
    .idx    (ra_d),
    .onehot (rin_oh)
  );

  // State and output registers; clear abandons any instruction in flight
  always_ff @(posedge Clock) begin
    if (!clear) begin
      state_q   <= ST_IDLE;
      opcode_q  <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      rout_q    <= '0;
      rin_q     <= '0;
      strb_q    <= '0;
      op_q      <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rc_q      <= rc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      rout_q    <= rout_d;
      rin_q     <= rin_d;
      strb_q    <= strb_d;
      op_q      <= op_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.illegal  = illegal_q;
  assign bus.Rout     = rout_q;
  assign bus.Rin      = rin_q;
  assign bus.Yin      = strb_q.yin;
  assign bus.Zhighin  = strb_q.zhighin;
  assign bus.Zlowin   = strb_q.zlowin;
  assign bus.Zhighout = strb_q.zhighout;
  assign bus.Zlowout  = strb_q.zlowout;
  assign bus.HIin     = strb_q.hiin;
  assign bus.LOin     = strb_q.loin;
  assign bus.op       = op_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench: a reference model pushes expected per-cycle control traces,
// a monitor pops and compares one entry per cycle and checks bus exclusivity.
module tb_alu_sequencer;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        illegal;
    logic [15:0] rout;
    logic [15:0] rin;
    logic        yin;
    logic        zhighin;
    logic        zlowin;
    logic        zhighout;
    logic        zlowout;
    logic        hiin;
    logic        loin;
    logic [4:0]  op;
  } obs_t;

  localparam logic [4:0] T_ADD = 5'd3;
  localparam logic [4:0] T_NOT = 5'd8;
  localparam logic [4:0] T_MUL = 5'd10;
  localparam logic [4:0] T_DIV = 5'd11;

  logic clk;
  logic clear;
  alu_sequencer_if bus ();

  alu_sequencer dut (
    .Clock (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   rem;
  int   n_cmp;
  int   n_bad;

  initial begin
    rem   = 0;
    n_cmp = 0;
    n_bad = 0;
  end

  // Expected control trace for one accepted instruction, built from the op's step list
  task automatic push_trace(input logic [31:0] w);
    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    obs_t o;
    opc = w[31:27];
    ra  = w[26:23];
    rb  = w[22:19];
    rc  = w[18:15];
    if (opc < 5'd1 || opc > 5'd11) begin
      o = '0; o.illegal = 1'b1; exp_q.push_back(o);
      return;
    end
    o = '0; o.busy = 1'b1; o.rout = 16'h0001 << rb; o.yin = 1'b1;
    exp_q.push_back(o);
    o = '0; o.busy = 1'b1; o.op = opc; o.zhighin = 1'b1; o.zlowin = 1'b1;
    if (opc != T_NOT && opc != 5'd9) o.rout = 16'h0001 << rc;
    exp_q.push_back(o);
    o = '0; o.busy = 1'b1; o.zlowout = 1'b1;
    if (opc == T_MUL || opc == T_DIV) o.loin = 1'b1;
    else                              o.rin  = 16'h0001 << ra;
    exp_q.push_back(o);
    if (opc == T_MUL || opc == T_DIV) begin
      o = '0; o.busy = 1'b1; o.zhighout = 1'b1; o.hiin = 1'b1;
      exp_q.push_back(o);
    end
    o = '0; o.busy = 1'b1; o.done = 1'b1;
    exp_q.push_back(o);
  endtask

  // Reference model: decides acceptance from the driven inputs at each edge
  always @(posedge clk) begin
    if (!clear) begin
      exp_q.delete();
      rem = 0;
    end else if (rem > 0) begin
      rem = rem - 1;
    end else if (bus.start) begin
      push_trace(bus.instr);
      if (bus.instr[31:27] >= 5'd1 && bus.instr[31:27] <= 5'd11) rem = exp_q.size();
    end
  end

  // Monitor: one expected entry per cycle (idle zeros when nothing is pending)
  always @(negedge clk) begin
    obs_t act;
    obs_t expv;
    int   drivers;
    act = {bus.busy, bus.done, bus.illegal, bus.Rout, bus.Rin, bus.Yin,
           bus.Zhighin, bus.Zlowin, bus.Zhighout, bus.Zlowout, bus.HIin,
           bus.LOin, bus.op};
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL trace t=%0t got=%h want=%h", $time, act, expv);
    end
    drivers = $countones(bus.Rout) + int'(bus.Zhighout) + int'(bus.Zlowout);
    n_cmp++;
    if (drivers > 1 || !$onehot0(bus.Rin)) begin
      n_bad++;
      $display("FAIL bus_excl t=%0t drivers=%0d rin=%h want drivers<=1 rin onehot0",
               $time, drivers, bus.Rin);
    end
  end

  task automatic cyc(input logic s, input logic [31:0] w, input logic c);
    bus.start = s;
    bus.instr = w;
    clear     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, $urandom, 1'b1);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [3:0] rc);
    logic [31:0] w;
    w = $urandom;
    w[31:15] = {opc, ra, rb, rc};
    return w;
  endfunction

  function automatic logic [4:0] rand_opc();
    int r;
    r = $urandom_range(0, 15);
    if (r < 12) return 5'(r);
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    clear     = 1'b0;
    bus.start = 1'b0;
    bus.instr = '0;
    // reset, with start asserted to show clear dominates
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h1A918000, 1'b0);
    idle(2);
    // ADD R5,R2,R3
    cyc(1'b1, 32'h1A918000, 1'b1);
    idle(6);
    // NOT R6,R2
    cyc(1'b1, mk(T_NOT, 4'd6, 4'd2, 4'd9), 1'b1);
    idle(6);
    // MUL rb=3 rc=4
    cyc(1'b1, mk(T_MUL, 4'd1, 4'd3, 4'd4), 1'b1);
    idle(7);
    // DIV back-to-back with an ADD: second start accepted right after FIN
    cyc(1'b1, mk(T_DIV, 4'd15, 4'd0, 4'd14), 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b1, mk(T_ADD, 4'd0, 4'd15, 4'd1), 1'b1);
    idle(6);
    // illegal opcode 11111, then opcode 0
    cyc(1'b1, mk(5'b11111, 4'd1, 4'd2, 4'd3), 1'b1);
    idle(3);
    cyc(1'b1, mk(5'b00000, 4'd1, 4'd2, 4'd3), 1'b1);
    idle(3);
    // ADD R4,R4,R4
    cyc(1'b1, mk(T_ADD, 4'd4, 4'd4, 4'd4), 1'b1);
    idle(6);
    // clear pulled low during T4 of an ADD
    cyc(1'b1, 32'h1A918000, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0);
    idle(6);
    // start held high with instr changing every cycle
    for (int i = 0; i < 30; i++)
      cyc(1'b1, mk(rand_opc(), 4'($urandom), 4'($urandom), 4'($urandom)), 1'b1);
    idle(6);
    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 2) == 0,
          mk(rand_opc(), 4'($urandom), 4'($urandom), 4'($urandom)),
          $urandom_range(0, 59) != 0);
    idle(8);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter OP_W, default 5, ALU op code width driven to data_path op.
REQ-002 SHALL have parameter NREG, default 16, general register count; only 16 is supported.
REQ-003 SHALL have port Clock  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port clear  in  1  reset; synchronous, active-low.
REQ-005 SHALL have port start  in  1  request to execute instr; sampled only in IDLE.
REQ-006 SHALL have port instr  in  32  instruction word: opcode[31:27], ra[26:23], rb[22:19], rc[18:15].
REQ-007 SHALL have port busy  out  1  high in every state except IDLE.
REQ-008 SHALL have port done  out  1  one-cycle pulse on return to IDLE after a legal instruction.
REQ-009 SHALL have port illegal  out  1  one-cycle pulse when an unknown opcode is accepted.
REQ-010 SHALL have port Rout  out  16  one-hot register-to-bus enables R0..R15.
REQ-011 SHALL have port Rin  out  16  one-hot bus-to-register load enables R0..R15.
REQ-012 SHALL have ports Yin, Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin  out  1 each  datapath strobes.
REQ-013 SHALL have port op  out  OP_W  ALU operation select; 0 when no ALU operation is in progress.

Function
REQ-014 Opcodes SHALL be: AND 00001, OR 00010, ADD 00011, SUB 00100, SHR 00101, SHL 00110, ROR 00111, NOT 01000, NEG 01001, MUL 01010, DIV 01011; all other values are illegal.
REQ-015 States SHALL be IDLE, T3, T4, T5, T6, FIN; every output is registered, and each state lasts exactly one cycle.
REQ-016 In IDLE with start=1, the sequencer SHALL latch instr. A legal opcode goes to T3. An illegal opcode asserts illegal for the next cycle and stays in IDLE.
REQ-017 T3: Rout[rb]=1, Yin=1.
REQ-018 T4 for binary ops: Rout[rc]=1, op=opcode, Zhighin=Zlowin=1.
REQ-019 T4 for NOT/NEG: no Rout asserted, op=opcode, Zhighin=Zlowin=1.
REQ-020 T5 for non-MUL/DIV: Zlowout=1, Rin[ra]=1, then go to FIN.
REQ-021 T5 for MUL/DIV: Zlowout=1, LOin=1, then go to T6.
REQ-022 T6 (MUL/DIV only): Zhighout=1, HIin=1, then go to FIN.
REQ-023 FIN: done=1, all strobes 0; next state IDLE.
REQ-024 Latency from the start-accept edge SHALL be 4 cycles to done for non-MUL/DIV and 5 for MUL/DIV. A new start SHALL be accepted in the cycle after FIN.
REQ-025 start while busy SHALL be ignored, with no queuing; instr changes while busy SHALL have no effect.
REQ-026 At most one of Rout[*], Zhighout, Zlowout SHALL be high in any cycle, and Rin SHALL be zero or one-hot.
REQ-027 ra=rb=rc (e.g. ADD R4,R4,R4) SHALL sequence normally; no hazard handling is required.

Reset
REQ-028 clear=0 at a rising edge SHALL force IDLE and drive every output (busy, done, illegal, Rout, Rin, strobes, op) to 0 from the next cycle, including mid-sequence.
REQ-029 An instruction interrupted by reset SHALL be abandoned, with no done and no later Rin pulse.

Structure
REQ-030 Opcode constants, state encoding, and instr field bit positions SHALL live in shared package cpu_ctrl_pkg, which the datapath ALU also uses.
REQ-031 A sub-module reg_decode_4to16 (4-bit index plus enable to 16-bit one-hot) SHALL be instantiated for Rout and for Rin.

Verification
REQ-032 ADD R5,R2,R3 (instr=0x1A918000), start for 1 cycle -> T3 Rout=0x0004,Yin; T4 Rout=0x0008,op=00011,Zhighin,Zlowin; T5 Zlowout,Rin=0x0020; FIN done=1; busy high 4 cycles.
REQ-033 NOT R6,R2 (opcode 01000, ra=6, rb=2) -> T4 Rout=0, op=01000; T5 Rin=0x0040; done 4 cycles after accept.
REQ-034 MUL rb=3, rc=4 -> T5 Zlowout+LOin; T6 Zhighout+HIin; Rin never asserted; done 5 cycles after accept.
REQ-035 Opcode 11111 with start -> illegal=1 for one cycle, busy stays 0, no strobes, no done.
REQ-036 Bench SHALL pull clear low during T4 of an ADD -> next cycle all outputs 0, state IDLE, no done. It SHALL also assert start continuously during a sequence -> exactly one instruction is executed per accept.
REQ-037 Bench SHALL check the REQ-026 bus-exclusivity assertion on every cycle of every scenario.
